// File: rtl/decoder_pkg.sv
// Purpose: shared opcode constants, control encodings and the opcode->control decode function.
// Latency: n/a (types, constants and a pure combinational function only).
// Backpressure: n/a.
package decoder_pkg;

    // Opcodes (top 4 bits of every instruction word)
    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_BRNZP  = 4'd1;
    localparam logic [3:0] OP_CMP    = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_MUL    = 4'd5;
    localparam logic [3:0] OP_DIV    = 4'd6;
    localparam logic [3:0] OP_LDR    = 4'd7;
    localparam logic [3:0] OP_STR    = 4'd8;
    localparam logic [3:0] OP_CONST  = 4'd9;
    localparam logic [3:0] OP_JMP    = 4'd10;
    localparam logic [3:0] OP_RECONV = 4'd11;
    localparam logic [3:0] OP_RET    = 4'd15;

    // Register write-back source select
    localparam logic [1:0] REG_MUX_ALU = 2'd0;
    localparam logic [1:0] REG_MUX_LSU = 2'd1;
    localparam logic [1:0] REG_MUX_IMM = 2'd2;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_DIV = 2'd3;

    // Next-PC select
    localparam logic [1:0] PC_MUX_INC = 2'd0;
    localparam logic [1:0] PC_MUX_BR  = 2'd1;
    localparam logic [1:0] PC_MUX_JMP = 2'd2;

    // Core FSM state in which the legacy unbuffered decoder sampled its instruction
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef struct packed {
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       nzp_we;
        logic [1:0] reg_mux;
        logic [1:0] alu_arith;
        logic       alu_out;
        logic [1:0] pc_mux;
        logic       ret;
        logic       reconv;
        logic       illegal;
    } ctrl_t;

    // Undefined opcodes (12-14) leave every control low and only raise illegal
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_NOP:    ;
            OP_BRNZP:  c.pc_mux = PC_MUX_BR;
            OP_CMP:    begin c.alu_out = 1'b1; c.nzp_we = 1'b1; end
            OP_ADD:    begin c.reg_we = 1'b1; c.reg_mux = REG_MUX_ALU; c.alu_arith = ALU_ADD; end
            OP_SUB:    begin c.reg_we = 1'b1; c.reg_mux = REG_MUX_ALU; c.alu_arith = ALU_SUB; end
            OP_MUL:    begin c.reg_we = 1'b1; c.reg_mux = REG_MUX_ALU; c.alu_arith = ALU_MUL; end
            OP_DIV:    begin c.reg_we = 1'b1; c.reg_mux = REG_MUX_ALU; c.alu_arith = ALU_DIV; end
            OP_LDR:    begin c.reg_we = 1'b1; c.mem_re = 1'b1; c.reg_mux = REG_MUX_LSU; end
            OP_STR:    c.mem_we = 1'b1;
            OP_CONST:  begin c.reg_we = 1'b1; c.reg_mux = REG_MUX_IMM; end
            OP_JMP:    c.pc_mux = PC_MUX_JMP;
            OP_RECONV: c.reconv = 1'b1;
            OP_RET:    c.ret = 1'b1;
            default:   c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_queue.sv
// Purpose: generic 2-entry valid/ready record queue with synchronous flush.
// Latency: 1 cycle push->head; no bypass, so an empty queue never shows the word being pushed.
// Backpressure: push_rdy drops when both entries are full; pop_rdy has no path to push_rdy.
module decode_queue #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push;
    logic         pop;

    assign push_rdy = (count_q != 2'd2) & ~reset;
    assign pop_vld  = (count_q != 2'd0) & ~reset;
    assign pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;

    // Next-state for storage, pointers and occupancy; reset and flush override push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (reset) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else if (flush) begin
            // Realign the read pointer so the next push becomes the head
            rd_ptr_d = wr_ptr_q;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: decodes fetched instructions into register/immediate/control records, buffered 2 deep.
// Latency: 1 cycle from accepted instruction to out_valid with its record.
// Backpressure: in_ready low when the queue is full, after a RET is accepted, or in reset.
module decode_stage
    import decoder_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 8,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rs,
    output logic [REG_AW-1:0]  out_rt,
    output logic [2:0]         out_nzp,
    output logic [IMM_W-1:0]   out_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_reg_we,
    output logic               out_mem_re,
    output logic               out_mem_we,
    output logic               out_nzp_we,
    output logic [1:0]         out_reg_mux,
    output logic [1:0]         out_alu_arith,
    output logic               out_alu_out,
    output logic [1:0]         out_pc_mux,
    output logic               out_ret,
    output logic               out_reconv,
    output logic               out_illegal,
    output logic               halted
);

    // Field layout assumes INSTR_W >= 4 + 3*REG_AW and IMM_W <= INSTR_W - 4
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [2:0]        nzp;
        logic [IMM_W-1:0]  imm;
        logic [PC_W-1:0]   pc;
        ctrl_t             ctrl;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    rec_t             in_rec;
    rec_t             out_rec;
    logic [REC_W-1:0] q_pop_dat;
    logic             q_push_rdy;
    logic             q_pop_vld;
    logic             halted_q, halted_d;
    logic             accept;

    // Combinational decode of the offered instruction
    always_comb begin
        in_rec      = '0;
        in_rec.rd   = in_instr[INSTR_W-5 -: REG_AW];
        in_rec.rs   = in_instr[INSTR_W-5-REG_AW -: REG_AW];
        in_rec.rt   = in_instr[INSTR_W-5-2*REG_AW -: REG_AW];
        in_rec.nzp  = in_instr[INSTR_W-5 -: 3];
        in_rec.imm  = in_instr[IMM_W-1:0];
        in_rec.pc   = in_pc;
        in_rec.ctrl = decode_ctrl(in_instr[INSTR_W-1 -: 4]);
    end

    assign in_ready = q_push_rdy & ~halted_q;
    assign accept   = in_valid & in_ready;

    // Halt latches on an accepted RET and only clears on flush or reset
    always_comb begin
        halted_d = halted_q;
        if (reset || flush) begin
            halted_d = 1'b0;
        end else if (accept && in_rec.ctrl.ret) begin
            halted_d = 1'b1;
        end
    end

    // Halt register
    always_ff @(posedge clk) begin
        halted_q <= halted_d;
    end

    assign halted = halted_q & ~reset;

    decode_queue #(
        .W (REC_W)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push_vld (in_valid & ~halted_q),
        .push_rdy (q_push_rdy),
        .push_dat (in_rec),
        .pop_vld  (q_pop_vld),
        .pop_rdy  (out_ready),
        .pop_dat  (q_pop_dat)
    );

    assign out_valid     = q_pop_vld;
    assign out_rec       = rec_t'(q_pop_dat);
    assign out_rd        = out_rec.rd;
    assign out_rs        = out_rec.rs;
    assign out_rt        = out_rec.rt;
    assign out_nzp       = out_rec.nzp;
    assign out_imm       = out_rec.imm;
    assign out_pc        = out_rec.pc;
    assign out_reg_we    = out_rec.ctrl.reg_we;
    assign out_mem_re    = out_rec.ctrl.mem_re;
    assign out_mem_we    = out_rec.ctrl.mem_we;
    assign out_nzp_we    = out_rec.ctrl.nzp_we;
    assign out_reg_mux   = out_rec.ctrl.reg_mux;
    assign out_alu_arith = out_rec.ctrl.alu_arith;
    assign out_alu_out   = out_rec.ctrl.alu_out;
    assign out_pc_mux    = out_rec.ctrl.pc_mux;
    assign out_ret       = out_rec.ctrl.ret;
    assign out_reconv    = out_rec.ctrl.reconv;
    assign out_illegal   = out_rec.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose: self-checking bench for decode_stage (default and wide parameter sets).
// Latency: expects records one cycle after acceptance.
// Backpressure: exercises full-queue, halt and flush stalls.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid, halted;
    logic [15:0] in_instr;
    logic [7:0]  in_pc;
    logic [3:0]  out_rd, out_rs, out_rt;
    logic [2:0]  out_nzp;
    logic [7:0]  out_imm, out_pc;
    logic        out_reg_we, out_mem_re, out_mem_we, out_nzp_we, out_alu_out;
    logic [1:0]  out_reg_mux, out_alu_arith, out_pc_mux;
    logic        out_ret, out_reconv, out_illegal;

    logic        w_flush, w_in_valid, w_out_ready;
    logic        w_in_ready, w_out_valid, w_halted;
    logic [23:0] w_in_instr;
    logic [7:0]  w_in_pc;
    logic [5:0]  w_out_rd, w_out_rs, w_out_rt;
    logic [2:0]  w_out_nzp;
    logic [11:0] w_out_imm;
    logic [7:0]  w_out_pc;
    logic        w_out_reg_we, w_out_mem_re, w_out_mem_we, w_out_nzp_we, w_out_alu_out;
    logic [1:0]  w_out_reg_mux, w_out_alu_arith, w_out_pc_mux;
    logic        w_out_ret, w_out_reconv, w_out_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] rd, rs, rt;
        logic [2:0] nzp;
        logic [7:0] imm, pc;
        logic       reg_we, mem_re, mem_we, nzp_we;
        logic [1:0] reg_mux, alu_arith;
        logic       alu_out;
        logic [1:0] pc_mux;
        logic       ret, reconv, illegal;
    } rec_t;

    rec_t mq[$];
    bit   m_halt;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_nzp(out_nzp),
        .out_imm(out_imm), .out_pc(out_pc),
        .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_nzp_we(out_nzp_we), .out_reg_mux(out_reg_mux), .out_alu_arith(out_alu_arith),
        .out_alu_out(out_alu_out), .out_pc_mux(out_pc_mux), .out_ret(out_ret),
        .out_reconv(out_reconv), .out_illegal(out_illegal), .halted(halted)
    );

    decode_stage #(.INSTR_W(24), .REG_AW(6), .IMM_W(12), .PC_W(8)) dut_w (
        .clk(clk), .reset(reset), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_rd(w_out_rd), .out_rs(w_out_rs), .out_rt(w_out_rt), .out_nzp(w_out_nzp),
        .out_imm(w_out_imm), .out_pc(w_out_pc),
        .out_reg_we(w_out_reg_we), .out_mem_re(w_out_mem_re), .out_mem_we(w_out_mem_we),
        .out_nzp_we(w_out_nzp_we), .out_reg_mux(w_out_reg_mux), .out_alu_arith(w_out_alu_arith),
        .out_alu_out(w_out_alu_out), .out_pc_mux(w_out_pc_mux), .out_ret(w_out_ret),
        .out_reconv(w_out_reconv), .out_illegal(w_out_illegal), .halted(w_halted)
    );

    // Reference decode straight from the opcode table
    function automatic rec_t ref_decode(input logic [15:0] i, input logic [7:0] pc);
        rec_t r;
        r     = '0;
        r.rd  = i[11:8];
        r.rs  = i[7:4];
        r.rt  = i[3:0];
        r.nzp = i[11:9];
        r.imm = i[7:0];
        r.pc  = pc;
        case (i[15:12])
            4'd0:  ;
            4'd1:  r.pc_mux = 2'd1;
            4'd2:  begin r.alu_out = 1'b1; r.nzp_we = 1'b1; end
            4'd3:  begin r.reg_we = 1'b1; r.alu_arith = 2'd0; end
            4'd4:  begin r.reg_we = 1'b1; r.alu_arith = 2'd1; end
            4'd5:  begin r.reg_we = 1'b1; r.alu_arith = 2'd2; end
            4'd6:  begin r.reg_we = 1'b1; r.alu_arith = 2'd3; end
            4'd7:  begin r.reg_we = 1'b1; r.mem_re = 1'b1; r.reg_mux = 2'd1; end
            4'd8:  r.mem_we = 1'b1;
            4'd9:  begin r.reg_we = 1'b1; r.reg_mux = 2'd2; end
            4'd10: r.pc_mux = 2'd2;
            4'd11: r.reconv = 1'b1;
            4'd15: r.ret = 1'b1;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    function automatic rec_t dut_rec();
        return {out_rd, out_rs, out_rt, out_nzp, out_imm, out_pc,
                out_reg_we, out_mem_re, out_mem_we, out_nzp_we, out_reg_mux, out_alu_arith,
                out_alu_out, out_pc_mux, out_ret, out_reconv, out_illegal};
    endfunction

    // One clock: drive inputs, advance the queue model at the edge, return after the falling edge
    task automatic cycle(input bit v, input logic [15:0] ins, input logic [7:0] pc,
                         input bit rdy, input bit fl);
        bit push, pop;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
        push = v && (mq.size() < 2) && !m_halt;
        pop  = rdy && (mq.size() > 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(ref_decode(ins, pc));
                if (ins[15:12] == 4'hF) m_halt = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL reset_valid_halt: got %b%b want 00", out_valid, halted); end
        n_cmp++; if (dut_rec() !== '0) begin n_bad++; $display("FAIL reset_payload: got %h want 0", dut_rec()); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        cycle(1, 16'h3123, 8'd5, 1, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_cmp++; if ({out_rd, out_rs, out_rt} !== 12'h123 || out_reg_we !== 1'b1 || out_alu_arith !== 2'd0 || out_pc !== 8'd5)
            begin n_bad++; $display("FAIL add_fields: got rd%h rs%h rt%h we%b ar%h pc%h", out_rd, out_rs, out_rt, out_reg_we, out_alu_arith, out_pc); end
        cycle(0, 16'h0, 8'd0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || dut_rec() !== '0) begin n_bad++; $display("FAIL add_empty: got v%b rec %h want 0", out_valid, dut_rec()); end
    endtask

    task automatic test_backpressure();
        cycle(1, 16'h9A7F, 8'd1, 0, 0);
        cycle(1, 16'h7456, 8'd2, 0, 0);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
        cycle(1, 16'h1111, 8'd3, 0, 0);
        n_cmp++; if (out_rd !== 4'hA || out_imm !== 8'h7F || out_reg_mux !== 2'd2 || out_pc !== 8'd1)
            begin n_bad++; $display("FAIL bp_const: got rd%h imm%h mux%h pc%h", out_rd, out_imm, out_reg_mux, out_pc); end
        cycle(0, 16'h0, 8'd0, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_mem_re !== 1'b1 || out_reg_mux !== 2'd1 || out_pc !== 8'd2)
            begin n_bad++; $display("FAIL bp_ldr: got v%b re%b mux%h pc%h", out_valid, out_mem_re, out_reg_mux, out_pc); end
        cycle(0, 16'h0, 8'd0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_third_dropped: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        cycle(1, 16'hC000, 8'd7, 0, 0);
        n_cmp++; if (out_illegal !== 1'b1 || {out_reg_we, out_mem_re, out_mem_we, out_nzp_we, out_reg_mux, out_alu_arith,
                                              out_alu_out, out_pc_mux, out_ret, out_reconv} !== 13'd0)
            begin n_bad++; $display("FAIL illegal: got %h want only illegal", dut_rec()); end
        cycle(0, 16'h0, 8'd0, 1, 0);
    endtask

    task automatic test_ret_halt();
        cycle(1, 16'hF000, 8'd8, 0, 0);
        n_cmp++; if (halted !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL ret_halt: got h%b r%b want 10", halted, in_ready); end
        cycle(1, 16'h3123, 8'd9, 0, 0);
        n_cmp++; if (out_ret !== 1'b1 || out_pc !== 8'd8) begin n_bad++; $display("FAIL ret_head: got ret%b pc%h", out_ret, out_pc); end
        cycle(0, 16'h0, 8'd0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || halted !== 1'b1) begin n_bad++; $display("FAIL ret_drain: got v%b h%b want 01", out_valid, halted); end
        cycle(0, 16'h0, 8'd0, 0, 1);
        n_cmp++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ret_flush: got h%b r%b want 01", halted, in_ready); end
    endtask

    task automatic test_flush();
        cycle(1, 16'h3123, 8'd1, 0, 0);
        cycle(1, 16'h4123, 8'd2, 0, 0);
        cycle(1, 16'h5123, 8'd3, 1, 1);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_rec() !== '0)
            begin n_bad++; $display("FAIL flush_full: got v%b r%b rec %h", out_valid, in_ready, dut_rec()); end
        cycle(0, 16'h0, 8'd0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_nothing_enqueued: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            ins[15:12] = 4'($urandom_range(0, 14));
            cycle(1, ins, 8'(k + 16), 1, 0);
            n_cmp++; if (out_valid !== 1'b1 || mq.size() != 1 || dut_rec() !== mq[0])
                begin n_bad++; $display("FAIL b2b_%0d: got %h want %h", k, dut_rec(), ins); end
        end
        cycle(0, 16'h0, 8'd0, 1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [15:0] ins;
            rec_t        exp;
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF && $urandom_range(0, 3) != 0) ins[15:12] = 4'h3;
            cycle($urandom_range(0, 3) != 0, ins, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
            exp = (mq.size() > 0) ? mq[0] : '0;
            n_cmp++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2 && !m_halt) || halted !== m_halt)
                begin n_bad++; $display("FAIL rand_status_%0d: got v%b r%b h%b want n=%0d h%b", k, out_valid, in_ready, halted, mq.size(), m_halt); end
            n_cmp++; if (dut_rec() !== exp) begin n_bad++; $display("FAIL rand_rec_%0d: got %h want %h", k, dut_rec(), exp); end
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1, 16'hF000, 8'd1, 0, 0);
        cycle(1, 16'h3123, 8'd2, 0, 0);
        reset = 1'b1; in_valid = 1'b1; in_instr = 16'h3123;
        #1;
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || halted !== 1'b0 || dut_rec() !== '0)
            begin n_bad++; $display("FAIL midreset_mask: got r%b v%b h%b rec %h", in_ready, out_valid, halted, dut_rec()); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        mq.delete(); m_halt = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b0)
            begin n_bad++; $display("FAIL midreset_after: got r%b v%b h%b want 100", in_ready, out_valid, halted); end
    endtask

    task automatic test_wide();
        w_in_instr = {4'h1, 6'h2B, 6'h07, 6'h32, 2'b01};
        w_in_pc    = 8'h44;
        w_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        n_cmp++; if (w_out_valid !== 1'b1 || w_out_nzp !== 3'd5 || w_out_pc_mux !== 2'd1 || w_out_pc !== 8'h44)
            begin n_bad++; $display("FAIL wide_br: got v%b nzp%h pcm%h pc%h", w_out_valid, w_out_nzp, w_out_pc_mux, w_out_pc); end
        n_cmp++; if (w_out_rd !== 6'h2B || w_out_rs !== 6'h07 || w_out_rt !== 6'h32 || w_out_imm !== 12'h7C9)
            begin n_bad++; $display("FAIL wide_fields: got rd%h rs%h rt%h imm%h", w_out_rd, w_out_rs, w_out_rt, w_out_imm); end
        w_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (w_out_valid !== 1'b0 || w_out_rd !== 6'h0) begin n_bad++; $display("FAIL wide_drain: got v%b rd%h", w_out_valid, w_out_rd); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 16'h3123; in_pc = 8'd0; out_ready = 1'b0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_instr = '0; w_in_pc = '0; w_out_ready = 1'b0;
        m_halt = 1'b0;
        repeat (2) @(posedge clk);
        in_valid = 1'b0;
        test_reset();
        test_add();
        test_backpressure();
        test_illegal();
        test_ret_halt();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised, buffered successor to the per-core instruction decoder. It accepts fetched instructions plus their PC over a valid/ready handshake and decodes them into register-address, immediate and control fields. Decoded records are held in a 2-entry output queue consumed by the execute stage over a second valid/ready handshake. Adds illegal-opcode flagging, sticky halt after RET, and synchronous flush for branch redirect.

Parameters:
INSTR_W, 16, instruction width; opcode is always instr[INSTR_W-1 -: 4]; legal only if INSTR_W >= 4+3*REG_AW
REG_AW, 4, register address width
IMM_W, 8, immediate width; IMM_W <= INSTR_W-4
PC_W, 8, program-counter tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous queue clear and halt clear
in_valid  in  1  instruction offered
in_ready  out  1  stage can accept
in_instr  in  INSTR_W  instruction word
in_pc  in  PC_W  PC of instruction
out_valid  out  1  head record valid
out_ready  in  1  consumer takes head
out_rd / out_rs / out_rt  out  REG_AW each  register addresses
out_nzp  out  3  branch condition mask
out_imm  out  IMM_W  immediate
out_pc  out  PC_W  PC tag
out_reg_we, out_mem_re, out_mem_we, out_nzp_we  out  1 each  enables
out_reg_mux  out  2  0=ALU, 1=LSU, 2=IMM
out_alu_arith  out  2  0=ADD, 1=SUB, 2=MUL, 3=DIV
out_alu_out  out  1  1=compare result
out_pc_mux  out  2  0=+1, 1=BRnzp, 2=JMP
out_ret, out_reconv, out_illegal  out  1 each  RET, RECONV, undefined opcode
halted  out  1  RET accepted; intake stopped

Behaviour:
- Field extraction: rd=instr[INSTR_W-5 -: REG_AW]; rs=next REG_AW bits below; rt=next REG_AW bits below; nzp=instr[INSTR_W-5 -: 3]; imm=instr[IMM_W-1:0].
- Opcodes: 0 NOP, 1 BRnzp (pc_mux=1), 2 CMP (alu_out=1, nzp_we=1), 3-6 ADD/SUB/MUL/DIV (reg_we=1, reg_mux=0, alu_arith=0..3), 7 LDR (reg_we, mem_re, reg_mux=1), 8 STR (mem_we), 9 CONST (reg_we, reg_mux=2), 10 JMP (pc_mux=2), 11 RECONV (reconv), 15 RET (ret). 12-14: all controls 0, illegal=1; record still enqueued.
- Decode is combinational on in_instr at push; record (fields, controls, pc) is registered into the queue.
- Queue: 2 entries, count 0..2. in_ready = (count<2) & ~halted & ~reset. No combinational path out_ready->in_ready.
- Push on in_valid&in_ready; pop on out_valid&out_ready; simultaneous push+pop at count 1 keeps count 1, new record becomes head next cycle.
- Latency: instruction pushed at edge N into empty queue gives out_valid=1 with its record in cycle after N.
- out_valid = (count>0). When count==0, all out_* payload outputs are 0.
- Pushing a RET record sets halted at the same edge; subsequent in_ready=0. Records already queued still drain.
- flush: at the edge, count->0, halted->0; any simultaneous push and pop are discarded. Takes priority over push/pop.
- reset: same as flush plus pointers cleared; all outputs 0, in_ready=0 during reset, 1 the cycle after reset deasserts.
- Reset or flush mid-stream: no partial record ever appears at output.

Decomposition:
- Package decoder_pkg: opcode constants, reg_mux/alu_arith/pc_mux encodings, CORE_DECODE state constant.
- Sub-module decode_queue: generic 2-entry valid/ready queue with flush, parametrised by record width; decode_stage packs the record into a vector.

Test Plan:
- Push ADD 0x3123 at pc 5, out_ready=1 -> next cycle out_valid=1, rd=1, rs=2, rt=3, reg_we=1, alu_arith=0, pc=5; then empty.
- out_ready=0, push CONST 0x9A7F, LDR 0x7456, third offered -> in_ready=0 after two; release: CONST (rd=10, imm=0x7F, reg_mux=2) then LDR (mem_re=1, reg_mux=1) in order.
- Push 0xC000 -> out_illegal=1, all enables 0.
- Push RET 0xF000, then ADD -> halted=1, in_ready=0, ADD not accepted; RET drains with out_ret=1; flush -> halted=0, in_ready=1.
- Queue full, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count 0, nothing enqueued.
- INSTR_W=24, REG_AW=6, IMM_W=12: push BRnzp with nzp=101 -> out_nzp=5, pc_mux=1, rd/rs/rt from 6-bit fields.
